// File: rtl/vote_logger_if.sv
// Voting front-end signal bundle: operator inputs (mode, raw buttons) and the
// tally/strobe outputs consumed by the result-mode display selector.
interface vote_logger_if;
  logic       mode;
  logic       candidate1_button_press;
  logic       candidate2_button_press;
  logic       candidate3_button_press;
  logic [6:0] candidate1_vote;
  logic [6:0] candidate2_vote;
  logic [6:0] candidate3_vote;
  logic [8:0] total_votes;
  logic       valid_vote_casted;

  modport master (
    output mode, candidate1_button_press, candidate2_button_press, candidate3_button_press,
    input  candidate1_vote, candidate2_vote, candidate3_vote, total_votes, valid_vote_casted
  );

  modport slave (
    input  mode, candidate1_button_press, candidate2_button_press, candidate3_button_press,
    output candidate1_vote, candidate2_vote, candidate3_vote, total_votes, valid_vote_casted
  );
endinterface

// File: rtl/vote_logger.sv
// EVM voting-mode front end: synchronises and debounces three candidate buttons,
// accepts one vote per clean press and keeps saturating per-candidate tallies.
module vote_logger #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [6:0]  MAX_VOTES       = 7'd99
) (
  input logic           clock,
  input logic           reset,
  vote_logger_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, PRESS_DB, CAST, REL_DB} state_t;

  state_t      state_q, state_d;
  logic [2:0]  sync1_q, sync2_q;
  logic [1:0]  sel_q, sel_d;
  logic [15:0] cnt_q, cnt_d;
  logic [6:0]  tally_q [3];
  logic [6:0]  tally_d [3];
  logic [8:0]  total_q, total_d;
  logic        pulse_q, pulse_d;

  logic [2:0]  b;
  logic        single;
  logic [1:0]  pressIdx;
  logic [2:0]  selOneHot;
  logic        cntLast;
  logic [6:0]  selTally;

  assign b         = sync2_q;
  assign single    = (b != 3'b000) && ((b & (b - 3'd1)) == 3'b000);
  assign selOneHot = 3'b001 << sel_q;
  assign cntLast   = (cnt_q == DEBOUNCE_CYCLES - 16'd1);

  always_comb begin
    pressIdx = 2'd0;
    case (b)
      3'b010:  pressIdx = 2'd1;
      3'b100:  pressIdx = 2'd2;
      default: pressIdx = 2'd0;
    endcase
  end

  always_comb begin
    selTally = tally_q[0];
    case (sel_q)
      2'd1:    selTally = tally_q[1];
      2'd2:    selTally = tally_q[2];
      default: selTally = tally_q[0];
    endcase
  end

  // Next-state logic; a vote is only committed in CAST, so aborts and resets
  // anywhere earlier can never leave a partial count behind.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    tally_d = tally_q;
    total_d = total_q;
    pulse_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (!bus.mode && single) begin
          sel_d   = pressIdx;
          cnt_d   = 16'd0;
          state_d = PRESS_DB;
        end
      end
      PRESS_DB: begin
        if (bus.mode || (b != selOneHot)) begin
          state_d = IDLE;
        end else if (cntLast) begin
          state_d = CAST;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      CAST: begin
        state_d = REL_DB;
        cnt_d   = 16'd0;
        if (selTally < MAX_VOTES) begin
          tally_d[sel_q] = selTally + 7'd1;
          total_d        = total_q + 9'd1;
          pulse_d        = 1'b1;
        end
      end
      REL_DB: begin
        if (b != 3'b000) begin
          cnt_d = 16'd0;
        end else if (cntLast) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      sync1_q    <= 3'b000;
      sync2_q    <= 3'b000;
      sel_q      <= 2'd0;
      cnt_q      <= 16'd0;
      tally_q[0] <= 7'd0;
      tally_q[1] <= 7'd0;
      tally_q[2] <= 7'd0;
      total_q    <= 9'd0;
      pulse_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync1_q    <= {bus.candidate3_button_press, bus.candidate2_button_press,
                     bus.candidate1_button_press};
      sync2_q    <= sync1_q;
      sel_q      <= sel_d;
      cnt_q      <= cnt_d;
      tally_q[0] <= tally_d[0];
      tally_q[1] <= tally_d[1];
      tally_q[2] <= tally_d[2];
      total_q    <= total_d;
      pulse_q    <= pulse_d;
    end
  end

  assign bus.candidate1_vote   = tally_q[0];
  assign bus.candidate2_vote   = tally_q[1];
  assign bus.candidate3_vote   = tally_q[2];
  assign bus.total_votes       = total_q;
  assign bus.valid_vote_casted = pulse_q;

endmodule

// File: tb/tb_vote_logger.sv
// Directed bench for vote_logger with a scoreboard of expected votes; each
// observed valid_vote_casted pulse is matched against the head of the queue.
module tb_vote_logger;

  localparam int DB  = 4;
  localparam int MAX = 99;

  typedef struct {
    int cand;
    int t1;
    int t2;
    int t3;
    int total;
    int cycle;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   passCount = 0;
  int   totalChecks = 0;
  int   modelTally [3];
  exp_t sbq [$];

  vote_logger_if bus ();

  vote_logger #(.DEBOUNCE_CYCLES(16'(DB)), .MAX_VOTES(7'(MAX))) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input int obs, input int expv);
    totalChecks++;
    assert (obs === expv) passCount++;
    else $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, expv);
  endtask

  task automatic waitEdges(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic setButtons(input logic [2:0] v);
    bus.candidate1_button_press = v[0];
    bus.candidate2_button_press = v[1];
    bus.candidate3_button_press = v[2];
  endtask

  task automatic checkTallies(input string tag);
    checkOutput({tag, "_c1"}, int'(bus.candidate1_vote), modelTally[0]);
    checkOutput({tag, "_c2"}, int'(bus.candidate2_vote), modelTally[1]);
    checkOutput({tag, "_c3"}, int'(bus.candidate3_vote), modelTally[2]);
    checkOutput({tag, "_total"}, int'(bus.total_votes),
                modelTally[0] + modelTally[1] + modelTally[2]);
  endtask

  // A clean single press from idle, long enough to qualify, in voting mode,
  // is counted unless that candidate is already saturated.
  task automatic applyStimulus(input logic [2:0] btns, input int hold, input int rel);
    exp_t e;
    int   idx;
    setButtons(btns);
    if (!bus.mode && $onehot(btns) && hold >= DB + 4) begin
      idx = btns[0] ? 0 : (btns[1] ? 1 : 2);
      if (modelTally[idx] < MAX) begin
        modelTally[idx]++;
        e.cand  = idx;
        e.t1    = modelTally[0];
        e.t2    = modelTally[1];
        e.t3    = modelTally[2];
        e.total = modelTally[0] + modelTally[1] + modelTally[2];
        e.cycle = cyc + DB + 4;
        sbq.push_back(e);
      end
    end
    waitEdges(hold);
    setButtons(3'b000);
    waitEdges(rel);
  endtask

  task automatic pulseReset();
    reset = 1'b1;
    waitEdges(2);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) modelTally[i] = 0;
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (!reset && bus.valid_vote_casted === 1'b1) begin
      checkOutput("pulse_expected", int'(sbq.size() > 0), 1);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        checkOutput("vote_latency", cyc, e.cycle);
        checkOutput("pulse_c1", int'(bus.candidate1_vote), e.t1);
        checkOutput("pulse_c2", int'(bus.candidate2_vote), e.t2);
        checkOutput("pulse_c3", int'(bus.candidate3_vote), e.t3);
        checkOutput("pulse_total", int'(bus.total_votes), e.total);
      end
    end
  end

  initial begin
    for (int i = 0; i < 3; i++) modelTally[i] = 0;
    bus.mode = 1'b0;
    setButtons(3'b000);
    reset = 1'b1;
    waitEdges(3);
    checkOutput("reset_pulse", int'(bus.valid_vote_casted), 0);
    checkTallies("reset");
    reset = 1'b0;
    waitEdges(2);

    $display("[TB] single clean press of candidate 2");
    applyStimulus(3'b010, 20, 10);
    checkTallies("press1");

    $display("[TB] bouncing candidate 1");
    setButtons(3'b001); waitEdges(2);
    setButtons(3'b000); waitEdges(1);
    setButtons(3'b001); waitEdges(2);
    setButtons(3'b000); waitEdges(12);
    checkTallies("bounce");

    $display("[TB] second button during press debounce");
    setButtons(3'b001); waitEdges(4);
    setButtons(3'b101); waitEdges(10);
    setButtons(3'b000); waitEdges(12);
    checkTallies("second_btn");
    applyStimulus(3'b101, 20, 12);
    checkTallies("dual_idle");

    $display("[TB] mode gating");
    bus.mode = 1'b1;
    applyStimulus(3'b001, 20, 12);
    bus.mode = 1'b0;
    waitEdges(2);
    checkTallies("mode_block");
    setButtons(3'b001); waitEdges(4);
    bus.mode = 1'b1; waitEdges(10);
    setButtons(3'b000); waitEdges(12);
    bus.mode = 1'b0; waitEdges(2);
    checkTallies("mode_abort");
    applyStimulus(3'b001, 10, 10);
    bus.mode = 1'b1; waitEdges(3);
    bus.mode = 1'b0; waitEdges(3);
    checkTallies("mode_toggle");

    $display("[TB] saturation of candidate 3");
    pulseReset();
    waitEdges(2);
    for (int p = 0; p < 101; p++) applyStimulus(3'b100, 8, 10);
    checkTallies("saturate");
    checkOutput("saturate_c3_max", int'(bus.candidate3_vote), 99);

    $display("[TB] reset during press debounce");
    applyStimulus(3'b010, 10, 10);
    setButtons(3'b010); waitEdges(4);
    reset = 1'b1; setButtons(3'b000);
    waitEdges(2);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) modelTally[i] = 0;
    checkTallies("reset_press");
    waitEdges(12);
    checkTallies("reset_press_after");

    $display("[TB] reset on the cast edge");
    setButtons(3'b001); waitEdges(DB + 3);
    reset = 1'b1; setButtons(3'b000);
    waitEdges(1);
    reset = 1'b0;
    waitEdges(12);
    checkTallies("reset_cast");
    applyStimulus(3'b001, 10, 10);
    checkTallies("post_reset_press");
    checkOutput("post_reset_c1", int'(bus.candidate1_vote), 1);

    checkOutput("pending_votes", sbq.size(), 0);
    $display("%0d/%0d checks passed", passCount, totalChecks);
    $finish;
  end

endmodule

// File: doc/vote_logger.md
Name: vote_logger

Overview:
- Voting-mode front end of the EVM. Takes the raw candidate push-buttons and produces the per-candidate vote tallies and the vote-cast strobe that the result-mode display selector consumes.
- Synchronises and debounces the buttons, accepts exactly one vote per clean press, and rejects ambiguous input.
- Tallies saturate at a two-digit maximum, because the display encodes the value 100 as blank.

Parameters:
- DEBOUNCE_CYCLES, 16'd50000, number of consecutive stable cycles required for both press and release qualification (sim: 4). Legal range 1..65535.
- MAX_VOTES, 7'd99, saturation value of each tally.

Ports:
- clock  input  1  system clock.
- reset  input  1  synchronous, active-high; clears all state on a rising clock edge.
- mode  input  1  0 = voting mode, 1 = result mode. Votes are accepted only when mode=0.
- candidate1_button_press  input  1  raw button, asynchronous, active-high.
- candidate2_button_press  input  1  raw button, asynchronous, active-high.
- candidate3_button_press  input  1  raw button, asynchronous, active-high.
- candidate1_vote  output  7  tally for candidate 1, range 0..MAX_VOTES.
- candidate2_vote  output  7  tally for candidate 2.
- candidate3_vote  output  7  tally for candidate 3.
- total_votes  output  9  sum of the three tallies, range 0..297.
- valid_vote_casted  output  1  one-cycle pulse, registered, on every accepted vote.

Behaviour:
- Reset values: all tallies 0, total_votes 0, valid_vote_casted 0, state IDLE, debounce counter 0, both synchroniser stages 0.
- Synchroniser: each button passes through a 2-flop synchroniser. The FSM sees only the synchronised vector b[2:0].
- "Single" means exactly one bit of b is 1. "None" means b == 3'b000.
- FSM states and transitions:
  - IDLE: if mode=0 and b is single, latch the candidate index into sel, clear the counter, go to PRESS_DB. Otherwise stay in IDLE.
  - PRESS_DB: if mode=1, or b no longer equals the one-hot of sel, go to IDLE with no vote. A change in b covers release, bounce, or a second button pressed. Otherwise, if the counter equals DEBOUNCE_CYCLES-1, go to CAST; else increment the counter.
  - CAST: lasts exactly one cycle, then go to REL_DB with the counter cleared.
    - If tally[sel] < MAX_VOTES: on that edge tally[sel] increments by 1, total_votes increments by 1, and valid_vote_casted is 1 for the following cycle.
    - If tally[sel] == MAX_VOTES: nothing changes and no pulse is produced (saturated; the vote is silently dropped).
  - REL_DB: if b is not None, clear the counter. Else, if the counter equals DEBOUNCE_CYCLES-1, go to IDLE; else increment the counter. mode is ignored in this state: a held button never re-votes, even across mode toggles.
- Latency: the raw press is first sampled at edge k. valid_vote_casted and the updated tally appear after edge k+DEBOUNCE_CYCLES+3. The pulse lasts exactly 1 cycle.
- One vote per press: holding a button indefinitely yields one vote. The next vote requires DEBOUNCE_CYCLES of all-released input and then a fresh qualified press.
- Simultaneous buttons: two or more buttons high in IDLE means no transition. Two or more during PRESS_DB aborts to IDLE. No vote is ever attributed in either case.
- Mode rules:
  - mode=1 blocks entry to PRESS_DB and aborts an in-progress PRESS_DB.
  - Tallies hold their values in result mode and are never cleared by mode changes.
- Reset mid-operation: reset takes priority in every state, including CAST. A vote that has not yet been counted is discarded, and the pulse is suppressed.
- Width rules:
  - Tallies are 7-bit unsigned and never exceed MAX_VOTES.
  - total_votes is 9-bit and always equals the sum of the three tallies; it is updated on the same edge as the tally.
- Counter width: 16 bits. No wrap is possible because the counter is compared to DEBOUNCE_CYCLES-1 before it increments.

Test Plan (DEBOUNCE_CYCLES=4, MAX_VOTES=99):
- Press 1: reset, mode=0, hold candidate2 for 20 cycles then release 10 cycles -> exactly one valid_vote_casted pulse, 7 edges after the first sample. Final state candidate2_vote=1, total_votes=1, others 0.
- Bounce: candidate1 toggled high 2 cycles, low 1, high 2, then low -> no pulse, all tallies 0.
- Second button: candidate1 held, candidate3 asserted during PRESS_DB -> abort, no pulse. Candidate1 and candidate3 asserted together from IDLE -> no vote.
- Mode gating:
  - With mode=1, press candidate1 for 20 cycles -> no pulse.
  - With mode=0, raise mode to 1 two cycles into PRESS_DB -> abort.
  - Tallies are unchanged across toggles.
- Saturation: cast 101 clean candidate3 presses -> 99 pulses, candidate3_vote=99, total_votes=99, no pulse on presses 100 and 101.
- Reset: assert reset during PRESS_DB, and separately on the CAST edge -> tallies 0, no pulse, FSM in IDLE. A following clean press yields tally 1.
